// File: rtl/uart_rx_ascii.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | uart_rx_ascii: 8N1 LSB-first UART receiver with oversampled mid-bit       |
// | sampling. Define UART_RX_ASCII_FILTER_EN to accept only bytes '/'..':'.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module uart_rx_ascii #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);
    localparam int DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_SAMP_W = $clog2(OVERSAMPLE);
    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(DIV - 1);
    localparam logic [c_SAMP_W-1:0] c_SAMP_MID  = c_SAMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_SAMP_W-1:0] c_SAMP_LAST = c_SAMP_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_sync1;
    logic                  r_rx_s;
    logic                  r_rx_prev;
    logic [1:0]            r_fill;
    logic                  r_armed;
    logic [c_DIV_W-1:0]    r_div_cnt;
    logic [c_SAMP_W-1:0]   r_samp_cnt;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  w_tick;
    logic                  w_start_edge;
    logic                  w_samp_mid;
    logic                  w_samp_last;
    logic                  w_byte_ok;
    logic                  w_valid_next;
    logic                  w_ferr_next;

    // r_armed blocks a line that is already low at reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_fill    <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_sync1   <= rxd;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
            r_fill    <= {r_fill[0], 1'b1};
            if (r_fill[1] && r_rx_s)
                r_armed <= 1'b1;
        end
    end

    assign w_tick       = (r_div_cnt == c_DIV_LAST);
    assign w_start_edge = r_armed & r_rx_prev & ~r_rx_s;
    assign w_samp_mid   = (r_samp_cnt == c_SAMP_MID);
    assign w_samp_last  = (r_samp_cnt == c_SAMP_LAST);

`ifdef UART_RX_ASCII_FILTER_EN
    assign w_byte_ok = (r_shift >= 8'h2F) && (r_shift <= 8'h3A);
`else
    assign w_byte_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge)
                    w_state_next = S_START;
            end
            S_START: begin
                if (w_tick && w_samp_mid)
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick && w_samp_last && (r_bit_cnt == 3'd7))
                    w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_tick && w_samp_last) begin
                    if (r_rx_s) begin
                        w_state_next = S_IDLE;
                        w_valid_next = w_byte_ok;
                    end else begin
                        w_state_next = S_BRK;
                        w_ferr_next  = 1'b1;
                    end
                end
            end
            S_BRK: begin
                if (r_rx_s)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Sample counter restarts after mid start bit, so each later wrap lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_samp_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            if (r_state == S_IDLE && w_start_edge) begin
                r_div_cnt  <= '0;
                r_samp_cnt <= '0;
            end else begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                if (r_state == S_IDLE || r_state == S_BRK)
                    r_samp_cnt <= '0;
                else if (w_tick)
                    r_samp_cnt <= ((r_state == S_START && w_samp_mid) || w_samp_last)
                                  ? '0 : r_samp_cnt + 1'b1;
            end
            if (r_state == S_IDLE) begin
                r_bit_cnt <= 3'd0;
            end else if (r_state == S_DATA && w_tick && w_samp_last) begin
                r_shift[r_bit_cnt] <= r_rx_s;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= w_valid_next;
            frame_err_o <= w_ferr_next;
            if (w_valid_next)
                data_o <= r_shift;
        end
    end

    assign busy_o = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ascii.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_uart_rx_ascii: randomized self-checking bench for uart_rx_ascii.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_uart_rx_ascii;
    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 100_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLK_FREQ / BAUD;
    localparam int LATENCY    = 2 + (BIT_CLKS * 19) / 2 + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned cyc = 0;
    logic [7:0]  obs_data[$];
    int unsigned obs_cyc[$];
    int          ferr_cnt = 0;
    int          overlap_cnt = 0;
    logic [7:0]  last_data = 8'h00;

    uart_rx_ascii #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .frame_err_o(frame_err_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            obs_data.push_back(data_o);
            obs_cyc.push_back(cyc);
        end
        if (frame_err_o === 1'b1)
            ferr_cnt <= ferr_cnt + 1;
        if (valid_o === 1'b1 && frame_err_o === 1'b1)
            overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1, "timeout");
    end

    // Reference: a frame yields a byte iff its stop bit is high and the byte passes the filter.
    function automatic bit model_accepts(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)
            return 1'b0;
`ifdef UART_RX_ASCII_FILTER_EN
        return (b >= 8'h2F) && (b <= 8'h3A);
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive_line(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_line(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++)
            drive_line(b[i], BIT_CLKS);
        drive_line(stop_bit, BIT_CLKS);
        if (model_accepts(b, stop_bit))
            last_data = b;
    endtask

    task automatic test_reset;
        int          base_v;
        int unsigned c0;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({data_o, valid_o, frame_err_o, busy_o} !== 11'h000) begin
            n_errors++;
            $display("FAIL reset_in: got data=%h v=%b fe=%b busy=%b expected 00 0 0 0",
                     data_o, valid_o, frame_err_o, busy_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_line(1'b1, 50);
        n_checks++;
        if ({data_o, valid_o, frame_err_o, busy_o} !== 11'h000 || obs_data.size() != 0) begin
            n_errors++;
            $display("FAIL reset_idle: got data=%h v=%b busy=%b pulses=%0d expected 00 0 0 0",
                     data_o, valid_o, busy_o, obs_data.size());
        end
        base_v = obs_data.size();
        c0 = cyc;
        send_frame(8'h35, 1'b1);
        drive_line(1'b1, 4);
        n_checks++;
        if (obs_data.size() - base_v != 1 || ferr_cnt != 0) begin
            n_errors++;
            $display("FAIL first_frame_count: got %0d valid, %0d ferr expected 1 valid, 0 ferr",
                     obs_data.size() - base_v, ferr_cnt);
        end else begin
            n_checks++;
            if (obs_data[base_v] !== 8'h35 || data_o !== 8'h35) begin
                n_errors++;
                $display("FAIL first_frame_data: got %h/%h expected 35", obs_data[base_v], data_o);
            end
            n_checks++;
            if (obs_cyc[base_v] - c0 != LATENCY) begin
                n_errors++;
                $display("FAIL latency: got %0d clk expected %0d", obs_cyc[base_v] - c0, LATENCY);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] frames[3];
        int         base_v;
        frames[0] = 8'h2F; frames[1] = 8'h3A; frames[2] = 8'h30;
        base_v = obs_data.size();
        for (int i = 0; i < 3; i++)
            send_frame(frames[i], 1'b1);
        drive_line(1'b1, 4);
        n_checks++;
        if (obs_data.size() - base_v != 3) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d valid expected 3", obs_data.size() - base_v);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs_data[base_v + i] !== frames[i]) begin
                    n_errors++;
                    $display("FAIL b2b_data[%0d]: got %h expected %h", i, obs_data[base_v + i], frames[i]);
                end
            end
        end
    endtask

    task automatic test_glitch;
        int base_v;
        int base_f;
        base_v = obs_data.size();
        base_f = ferr_cnt;
        drive_line(1'b0, 5);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_errors++;
            $display("FAIL glitch_busy_hi: got %b expected 1", busy_o);
        end
        drive_line(1'b1, 30);
        n_checks++;
        if (busy_o !== 1'b0 || obs_data.size() != base_v || ferr_cnt != base_f) begin
            n_errors++;
            $display("FAIL glitch_reject: got busy=%b valid=%0d ferr=%0d expected 0 0 0",
                     busy_o, obs_data.size() - base_v, ferr_cnt - base_f);
        end
    endtask

    task automatic test_frame_error;
        int         base_v;
        int         base_f;
        logic [7:0] prev;
        prev   = last_data;
        base_v = obs_data.size();
        base_f = ferr_cnt;
        send_frame(8'h31, 1'b0);
        drive_line(1'b0, 40);
        drive_line(1'b1, 20);
        n_checks++;
        if (ferr_cnt - base_f != 1 || obs_data.size() != base_v) begin
            n_errors++;
            $display("FAIL ferr_count: got ferr=%0d valid=%0d expected 1 0",
                     ferr_cnt - base_f, obs_data.size() - base_v);
        end
        n_checks++;
        if (data_o !== prev || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL ferr_hold: got data=%h busy=%b expected %h 0", data_o, busy_o, prev);
        end
        send_frame(8'h32, 1'b1);
        drive_line(1'b1, 4);
        n_checks++;
        if (obs_data.size() - base_v != 1 || data_o !== 8'h32) begin
            n_errors++;
            $display("FAIL ferr_recover: got %0d valid data=%h expected 1 32",
                     obs_data.size() - base_v, data_o);
        end
    endtask

    task automatic test_reset_mid_frame;
        int         base_v;
        int         base_f;
        logic [7:0] b;
        b = 8'h39;
        base_v = obs_data.size();
        base_f = ferr_cnt;
        drive_line(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++)
            drive_line(b[i], BIT_CLKS);
        drive_line(b[4], BIT_CLKS / 2);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({data_o, valid_o, frame_err_o, busy_o} !== 11'h000) begin
            n_errors++;
            $display("FAIL midreset_out: got data=%h v=%b fe=%b busy=%b expected 00 0 0 0",
                     data_o, valid_o, frame_err_o, busy_o);
        end
        last_data = 8'h00;
        rxd = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        drive_line(1'b1, 40);
        n_checks++;
        if (obs_data.size() != base_v || ferr_cnt != base_f || busy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_quiet: got valid=%0d ferr=%0d busy=%b expected 0 0 0",
                     obs_data.size() - base_v, ferr_cnt - base_f, busy_o);
        end
        send_frame(8'h34, 1'b1);
        drive_line(1'b1, 4);
        n_checks++;
        if (obs_data.size() - base_v != 1 || data_o !== 8'h34) begin
            n_errors++;
            $display("FAIL midreset_next: got %0d valid data=%h expected 1 34",
                     obs_data.size() - base_v, data_o);
        end
    endtask

    task automatic test_low_at_reset;
        int base_v;
        int base_f;
        base_v = obs_data.size();
        base_f = ferr_cnt;
        rxd   = 1'b0;
        rst_n = 1'b0;
        last_data = 8'h00;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        drive_line(1'b0, 40);
        n_checks++;
        if (busy_o !== 1'b0 || obs_data.size() != base_v || ferr_cnt != base_f) begin
            n_errors++;
            $display("FAIL low_at_reset: got busy=%b valid=%0d ferr=%0d expected 0 0 0",
                     busy_o, obs_data.size() - base_v, ferr_cnt - base_f);
        end
        drive_line(1'b1, 20);
        send_frame(8'h33, 1'b1);
        drive_line(1'b1, 4);
        n_checks++;
        if (obs_data.size() - base_v != 1 || data_o !== 8'h33) begin
            n_errors++;
            $display("FAIL low_at_reset_next: got %0d valid data=%h expected 1 33",
                     obs_data.size() - base_v, data_o);
        end
    endtask

    task automatic test_filter;
        int base_v;
        int exp_n;
        base_v = obs_data.size();
        exp_n  = model_accepts(8'h41, 1'b1) ? 1 : 0;
        send_frame(8'h41, 1'b1);
        drive_line(1'b1, 4);
        n_checks++;
        if (obs_data.size() - base_v != exp_n || data_o !== last_data) begin
            n_errors++;
            $display("FAIL filter_41: got %0d valid data=%h expected %0d %h",
                     obs_data.size() - base_v, data_o, exp_n, last_data);
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        bit         stop_ok;
        int         exp_f;
        int         base_v;
        int         base_f;
        base_v = obs_data.size();
        base_f = ferr_cnt;
        exp_f  = 0;
        for (int n = 0; n < 20; n++) begin
            b       = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h2F, 8'h3A)) : 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            if (model_accepts(b, stop_ok))
                exp_q.push_back(b);
            if (!stop_ok)
                exp_f++;
            send_frame(b, stop_ok);
            drive_line(1'b1, stop_ok ? $urandom_range(0, 12) : $urandom_range(4, 12));
        end
        drive_line(1'b1, 20);
        n_checks++;
        if (obs_data.size() - base_v != exp_q.size() || ferr_cnt - base_f != exp_f) begin
            n_errors++;
            $display("FAIL rand_counts: got %0d valid %0d ferr expected %0d valid %0d ferr",
                     obs_data.size() - base_v, ferr_cnt - base_f, exp_q.size(), exp_f);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (obs_data[base_v + i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL rand_data[%0d]: got %h expected %h", i, obs_data[base_v + i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (data_o !== last_data) begin
            n_errors++;
            $display("FAIL rand_hold: got %h expected %h", data_o, last_data);
        end
    endtask

    task automatic test_no_overlap;
        n_checks++;
        if (overlap_cnt != 0) begin
            n_errors++;
            $display("FAIL no_overlap: got %0d cycles with valid and frame_err expected 0", overlap_cnt);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_filter();
        test_low_at_reset();
        test_random();
        test_no_overlap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
